// File: rtl/alu_mdu_seq_if.sv
// Operation/result bundle between the EX-stage issue logic and the execute unit.
// Both channels use valid/ready: a transfer happens on a rising clk edge where valid and ready are both high;
// a producer holding valid keeps its payload unchanged until that edge, and ready may depend on the other side's valid.
interface alu_mdu_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic            op_m;
  logic [3:0]      select;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out;
  logic            busy;

  modport master (
    output in_valid, op_m, select, a, b, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, op_m, select, a, b, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/alu_mdu_seq.sv
// EX-stage execute unit: single-cycle integer ALU plus iterative multiply/divide on operand magnitudes.
// One shared 2*XLEN accumulator holds {hi,lo} of the product or {remainder,quotient} of the divide.
module alu_mdu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic         clk,
  input  logic         rst,
  alu_mdu_seq_if.slave bus,
  output logic [1:0]   dbg_state_o
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q;
  logic [XLEN-1:0]   out_q;
  logic [XLEN-1:0]   dvs_q;
  logic [2*XLEN-1:0] acc_q;
  logic [2*XLEN-1:0] acc_d;
  logic [SHW-1:0]    cnt_q;
  logic              neg_q;
  logic [2:0]        op_q;

  logic              accept;
  logic              a_sgn, b_sgn, a_neg, b_neg, special;
  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   mag_a, mag_b, alu_res, spec_res, iter_res, quo, rmd;
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] prod;

  assign bus.in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_MUL) | (state_q == S_DIV);
  assign bus.out       = out_q;
  assign dbg_state_o   = state_q;

  always_comb begin
    shamt   = bus.b[SHW-1:0];
    alu_res = '0;
    case (bus.select)
      4'b0000: alu_res = bus.a + bus.b;
      4'b1000: alu_res = bus.a + ~bus.b + XLEN'(1);
      4'b0001: alu_res = bus.a << shamt;
      4'b0101: alu_res = bus.a >> shamt;
      4'b1101: alu_res = $signed(bus.a) >>> shamt;
      4'b0010: alu_res = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      4'b0011: alu_res = {{(XLEN-1){1'b0}}, bus.a < bus.b};
      4'b1010,
      4'b1011: alu_res = {{(XLEN-1){1'b0}}, bus.a == bus.b};
      4'b0100: alu_res = bus.a ^ bus.b;
      4'b0110: alu_res = bus.a | bus.b;
      4'b0111: alu_res = bus.a & bus.b;
      4'b1110: alu_res = bus.a;
      4'b1111: alu_res = bus.b;
      default: alu_res = '0;
    endcase
  end

  // Operand signedness by M opcode: mul/mulh/mulhsu/div/rem treat a as signed; only mul/mulh/div/rem treat b so.
  always_comb begin
    a_sgn    = bus.select[2] ? ~bus.select[0] : (bus.select[1:0] != 2'b11);
    b_sgn    = bus.select[2] ? ~bus.select[0] : ~bus.select[1];
    a_neg    = a_sgn & bus.a[XLEN-1];
    b_neg    = b_sgn & bus.b[XLEN-1];
    mag_a    = a_neg ? -bus.a : bus.a;
    mag_b    = b_neg ? -bus.b : bus.b;
    special  = bus.select[2] & ((bus.b == '0) |
               (~bus.select[0] & (bus.a == MIN_NEG) & (bus.b == '1)));
    if (bus.b == '0) spec_res = bus.select[1] ? bus.a : '1;
    else             spec_res = bus.select[1] ? '0 : bus.a;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_trial = div_shift - {1'b0, dvs_q};
    if (state_q == S_DIV)
      acc_d = {div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0],
               acc_q[XLEN-2:0], ~div_trial[XLEN]};
    else
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
    prod = neg_q ? -acc_d : acc_d;
    quo  = acc_d[XLEN-1:0];
    rmd  = acc_d[2*XLEN-1:XLEN];
    if (state_q == S_MUL)
      iter_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op_q[1])
      iter_res = neg_q ? -rmd : rmd;
    else
      iter_res = neg_q ? -quo : quo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      op_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_q  <= bus.select[2:0];
            cnt_q <= SHW'(XLEN-1);
            if (!bus.op_m) begin
              out_q   <= alu_res;
              state_q <= S_DONE;
            end else if (special) begin
              out_q   <= spec_res;
              state_q <= S_DONE;
            end else begin
              // Remainder sign follows the dividend only; every other result sign is the xor.
              neg_q   <= a_neg ^ (b_neg & ~(bus.select[2] & bus.select[1]));
              acc_q   <= {{XLEN{1'b0}}, bus.select[2] ? mag_a : mag_b};
              dvs_q   <= bus.select[2] ? mag_b : mag_a;
              state_q <= bus.select[2] ? S_DIV : S_MUL;
            end
          end else if ((state_q == S_DONE) && bus.out_ready) begin
            state_q <= S_IDLE;
          end
        end
        S_MUL, S_DIV: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == '0) begin
            out_q   <= iter_res;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed and randomised bench for alu_mdu_seq: results queued when an op is driven, compared when delivered.
module tb_alu_mdu_seq;
  localparam int XLEN = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  logic [XLEN-1:0] exp_q[$];

  alu_mdu_seq_if #(.XLEN(XLEN)) bus ();

  alu_mdu_seq #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  function automatic logic [31:0] model(input bit m, input logic [3:0] sel,
                                        input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] pa, pb, p;
    logic signed [31:0] sv;
    int sa, sb;
    logic [4:0] sh;
    sa = a; sb = b; sv = a; sh = b[4:0];
    if (!m) begin
      case (sel)
        4'b0000: return a + b;
        4'b1000: return a - b;
        4'b0001: return a << sh;
        4'b0101: return a >> sh;
        4'b1101: return sv >>> sh;
        4'b0010: return (sa < sb) ? 32'd1 : 32'd0;
        4'b0011: return (a < b) ? 32'd1 : 32'd0;
        4'b1010, 4'b1011: return (a == b) ? 32'd1 : 32'd0;
        4'b0100: return a ^ b;
        4'b0110: return a | b;
        4'b0111: return a & b;
        4'b1110: return a;
        4'b1111: return b;
        default: return 32'd0;
      endcase
    end
    pa = {{32{a[31]}}, a};
    pb = {{32{b[31]}}, b};
    case (sel[2:0])
      3'd0: begin p = pa * pb; return p[31:0]; end
      3'd1: begin p = pa * pb; return p[63:32]; end
      3'd2: begin pb = {32'd0, b}; p = pa * pb; return p[63:32]; end
      3'd3: begin pa = {32'd0, a}; pb = {32'd0, b}; p = pa * pb; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op with out_ready=1, then check latency, busy span and the delivered result.
  task automatic do_op(input bit m, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input int exp_lat, input string tag);
    int lat;
    int busy_n;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op_m = m; bus.select = sel; bus.a = a; bus.b = b; bus.out_ready = 1'b1;
    #1 check({tag, ":in_ready"}, bus.in_ready, 1);
    exp_q.push_back(expv);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.select = 4'($urandom_range(0, 15));
    lat = 1; busy_n = 0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    check({tag, ":latency"}, lat, exp_lat);
    if (exp_lat > 1) check({tag, ":busy_cycles"}, busy_n, exp_lat - 1);
    check({tag, ":result"}, bus.out, exp_q.pop_front());
  endtask

  initial begin
    bit          m;
    logic [3:0]  sel;
    logic [31:0] ra, rb;
    int          lat;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op_m = 1'b0; bus.select = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst:out_valid", bus.out_valid, 0);
    check("rst:busy", bus.busy, 0);
    check("rst:out", bus.out, 0);
    check("rst:state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst:in_ready", bus.in_ready, 1);

    do_op(0, 4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, "add");
    do_op(0, 4'b1000, 32'h0, 32'h1, 32'hFFFF_FFFF, 1, "sub");
    do_op(0, 4'b1101, 32'h8000_0000, 32'h21, 32'hC000_0000, 1, "sra");
    do_op(0, 4'b0011, 32'h1, 32'hFFFF_FFFF, 32'h1, 1, "sltu");
    do_op(0, 4'b0010, 32'h1, 32'hFFFF_FFFF, 32'h0, 1, "slt");
    do_op(0, 4'b1010, 32'h55, 32'h55, 32'h1, 1, "eq");
    do_op(0, 4'b1001, 32'h55, 32'h55, 32'h0, 1, "bad_code");
    do_op(0, 4'b1111, 32'h1, 32'hABCD, 32'hABCD, 1, "pass_b");

    do_op(1, 4'b0000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    do_op(1, 4'b0001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
    do_op(1, 4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    do_op(1, 4'b0010, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33, "mulhsu");

    do_op(1, 4'b0100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33, "div");
    do_op(1, 4'b0110, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33, "rem");
    do_op(1, 4'b1101, 32'd100, 32'd7, 32'd14, 33, "divu_sel3");
    do_op(1, 4'b0100, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1, "div0");
    do_op(1, 4'b0110, 32'h1234, 32'h0, 32'h1234, 1, "rem0");
    do_op(1, 4'b0101, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1, "divu0");
    do_op(1, 4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    do_op(1, 4'b0110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_ovf");

    // Backpressure: result must hold while out_ready is low.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op_m = 1'b0; bus.select = 4'b0000; bus.a = 32'd5; bus.b = 32'd6;
    bus.out_ready = 1'b0;
    exp_q.push_back(32'd11);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp:out_valid", bus.out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      check("bp:hold_valid", bus.out_valid, 1);
      check("bp:hold_out", bus.out, exp_q[0]);
      check("bp:in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b1; bus.select = 4'b0100; bus.a = 32'hF0F0; bus.b = 32'h0FF0; bus.out_ready = 1'b1;
    #1 check("bp:release_ready", bus.in_ready, 1);
    check("bp:result", bus.out, exp_q.pop_front());
    exp_q.push_back(32'h0000_FF00);
    @(negedge clk);
    check("b2b:valid1", bus.out_valid, 1);
    check("b2b:result1", bus.out, exp_q.pop_front());
    bus.select = 4'b1000; bus.a = 32'd10; bus.b = 32'd3;
    #1 check("b2b:in_ready", bus.in_ready, 1);
    exp_q.push_back(32'd7);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("b2b:valid2", bus.out_valid, 1);
    check("b2b:result2", bus.out, exp_q.pop_front());

    // Reset in the middle of a divu discards it.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op_m = 1'b1; bus.select = 4'b0101; bus.a = 32'd100; bus.b = 32'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid:busy_before", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("mid:out_valid", bus.out_valid, 0);
    check("mid:busy", bus.busy, 0);
    check("mid:out", bus.out, 0);
    @(negedge clk);
    rst = 1'b0;
    do_op(1, 4'b0101, 32'd100, 32'd7, 32'd14, 33, "post_rst_divu");

    for (int i = 0; i < 24; i++) begin
      m   = 1'($urandom_range(0, 1));
      sel = 4'($urandom_range(0, 15));
      ra  = $urandom;
      rb  = (i % 6 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom);
      if (!m) lat = 1;
      else if (sel[2] && (rb == 0 || (!sel[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF))) lat = 1;
      else lat = 33;
      do_op(m, sel, ra, rb, model(m, sel, ra, rb), lat, "rnd");
    end

    check("end:queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
